// File: rtl/qmod_pkg.sv
// qmod_pkg: shared constants and types for the quadrature modulator.
//   AMP_W          coefficient (amplitude) width
//   TAB_W          sine table sample width
//   OUT_W          output sample width
//   PTOS_W         points-per-cycle input width
//   TABLE_BITS_DEF default log2 of the sine table depth
//   qmod_state_e   run/idle state encoding
//   msb_index()    position of the highest set bit (0 when the input is 0)
package qmod_pkg;

    localparam int AMP_W          = 32;
    localparam int TAB_W          = 16;
    localparam int OUT_W          = 64;
    localparam int PTOS_W         = 16;
    localparam int TABLE_BITS_DEF = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } qmod_state_e;

    function automatic logic [4:0] msb_index(input logic [PTOS_W-1:0] value);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < PTOS_W; i++) begin
            if (value[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/qmod_sin_rom.sv
// qmod_sin_rom: full-cycle sine table, 2^TABLE_BITS entries of TAB_W bits,
// holding round(32767*sin(2*pi*a/D)). Two independent registered read ports
// with one cycle of latency.
//   clock, reset_n      clock and asynchronous active-low reset
//   addr_sin, addr_cos  read addresses
//   sin_val, cos_val    registered table values for the two addresses
module qmod_sin_rom
    import qmod_pkg::*;
#(
    parameter int TABLE_BITS = TABLE_BITS_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [TABLE_BITS-1:0]   addr_sin,
    input  logic [TABLE_BITS-1:0]   addr_cos,
    output logic signed [TAB_W-1:0] sin_val,
    output logic signed [TAB_W-1:0] cos_val
);

    localparam int  DEPTH = 1 << TABLE_BITS;
    localparam real PI_C  = 3.14159265358979323846;

    logic signed [TAB_W-1:0] rom_s [DEPTH];

    // Each entry is an elaboration-time constant; rounding is half away from zero.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam real ANG_C    = 2.0 * PI_C * real'(g) / real'(DEPTH);
        localparam real SCALED_C = 32767.0 * $sin(ANG_C);
        localparam int  VAL_I_C  = (SCALED_C >= 0.0) ? $rtoi(SCALED_C + 0.5)
                                                     : $rtoi(SCALED_C - 0.5);
        localparam logic signed [TAB_W-1:0] VAL_C = VAL_I_C[TAB_W-1:0];
        assign rom_s[g] = VAL_C;
    end

    // Registered dual-port read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sin_val <= {TAB_W{1'b0}};
            cos_val <= {TAB_W{1'b0}};
        end else begin
            sin_val <= rom_s[addr_sin];
            cos_val <= rom_s[addr_cos];
        end
    end

endmodule

// File: rtl/quadrature_modulator.sv
// quadrature_modulator: data_out = amp_i*sin[k] + amp_q*cos[k], one sample
// per sample_tick while running, with N = 2^clamp(floor(log2 P), 2, TABLE_BITS)
// points per carrier cycle. Four-stage pipeline: address, table read,
// products, sum; data_valid_out follows the tick edge by three cycles.
//   clock, reset_n      clock and asynchronous active-low reset
//   enable              run request (low = idle)
//   ptos_x_ciclo        points per cycle, latched when entering RUN
//   amp_i, amp_q        signed amplitudes, loaded into pending by amp_valid
//   sample_tick         request one sample (ignored unless running)
//   data_out            signed modulated sample
//   data_valid_out      data_out strobe
//   cycle_start         with data_valid_out when the sample had k = 0
//   running             high while in RUN
// Build option QMOD_COEF_SYNC_EN: when defined, pending coefficients move to
// the active set only on a k = 0 tick (or every cycle while idle); otherwise
// they move on the edge after amp_valid.
module quadrature_modulator
    import qmod_pkg::*;
#(
    parameter int TABLE_BITS = TABLE_BITS_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [PTOS_W-1:0]       ptos_x_ciclo,
    input  logic signed [AMP_W-1:0] amp_i,
    input  logic signed [AMP_W-1:0] amp_q,
    input  logic                    amp_valid,
    input  logic                    sample_tick,
    output logic signed [OUT_W-1:0] data_out,
    output logic                    data_valid_out,
    output logic                    cycle_start,
    output logic                    running
);

    localparam logic [4:0]            TB5_C     = 5'(TABLE_BITS);
    localparam logic [TABLE_BITS-1:0] K_ZERO_C  = {TABLE_BITS{1'b0}};
    localparam logic [TABLE_BITS-1:0] K_ONE_C   = {{(TABLE_BITS-1){1'b0}}, 1'b1};
    localparam logic [TABLE_BITS-1:0] QUARTER_C = {2'b01, {(TABLE_BITS-2){1'b0}}};

    qmod_state_e state_r, next_state_s;
    logic        start_s, tick_run_s, xfer_s;

    logic [4:0]            msb_s, s_s, shift_s, shift_r;
    logic [TABLE_BITS-1:0] kmax_s, kmax_r, k_r, addr_sin_s;

    logic signed [AMP_W-1:0] pend_i_r, pend_q_r, act_i_r, act_q_r;
    logic signed [AMP_W-1:0] coef_i_s, coef_q_s;

    logic [TABLE_BITS-1:0]   addr_sin_r, addr_cos_r;
    logic signed [AMP_W-1:0] coef_i1_r, coef_q1_r, coef_i2_r, coef_q2_r;
    logic signed [TAB_W-1:0] sin_s, cos_s;
    logic signed [47:0]      prod_i_r, prod_q_r;
    logic signed [48:0]      sum_s;
    logic                    v1_r, v2_r, v3_r, cs1_r, cs2_r, cs3_r;

    // Next-state logic: the state simply follows enable.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) next_state_s = RUN;
                else        next_state_s = IDLE;
            end
            RUN: begin
                if (enable) next_state_s = RUN;
                else        next_state_s = IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    assign start_s    = (state_r == IDLE) && (next_state_s == RUN);
    assign tick_run_s = sample_tick && (state_r == RUN);
    assign running    = (state_r == RUN);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= next_state_s;
    end

    // Points-per-cycle exponent clamped to [2, TABLE_BITS]; derives the
    // address shift (log2 of table step) and the last index N-1.
    always_comb begin
        msb_s = msb_index(ptos_x_ciclo);
        s_s   = msb_s;
        if (msb_s < 5'd2) begin
            s_s = 5'd2;
        end else if (msb_s > TB5_C) begin
            s_s = TB5_C;
        end else begin
            s_s = msb_s;
        end
        shift_s = TB5_C - s_s;
        kmax_s  = TABLE_BITS'((32'd1 << s_s) - 32'd1);
    end

    // Latch the carrier geometry when entering RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_r <= 5'd0;
            kmax_r  <= K_ZERO_C;
        end else if (start_s) begin
            shift_r <= shift_s;
            kmax_r  <= kmax_s;
        end
    end

    // Sample index: restarts on entry to RUN, wraps after N-1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k_r <= K_ZERO_C;
        end else if (start_s) begin
            k_r <= K_ZERO_C;
        end else if (tick_run_s) begin
            k_r <= (k_r == kmax_r) ? K_ZERO_C : (k_r + K_ONE_C);
        end
    end

`ifdef QMOD_COEF_SYNC_EN
    // Coefficients change only at a carrier-cycle boundary, or freely while idle.
    assign xfer_s = (state_r == IDLE) || (tick_run_s && (k_r == K_ZERO_C));
`else
    logic amp_valid_d_r;

    // Delayed strobe: the active set picks up pending one edge after amp_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) amp_valid_d_r <= 1'b0;
        else          amp_valid_d_r <= amp_valid;
    end

    assign xfer_s = amp_valid_d_r;
`endif

    // Pending and active coefficient registers. A coincident amp_valid lands
    // in pending and moves to active at the next transfer opportunity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_i_r <= {AMP_W{1'b0}};
            pend_q_r <= {AMP_W{1'b0}};
            act_i_r  <= {AMP_W{1'b0}};
            act_q_r  <= {AMP_W{1'b0}};
        end else begin
            if (amp_valid) begin
                pend_i_r <= amp_i;
                pend_q_r <= amp_q;
            end
            if (xfer_s) begin
                act_i_r <= pend_i_r;
                act_q_r <= pend_q_r;
            end
        end
    end

    // A tick that coincides with a transfer already uses the incoming values.
    assign coef_i_s   = xfer_s ? pend_i_r : act_i_r;
    assign coef_q_s   = xfer_s ? pend_q_r : act_q_r;
    assign addr_sin_s = k_r << shift_r;

    // Stage 1: table addresses and coefficient snapshot for the tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_sin_r <= K_ZERO_C;
            addr_cos_r <= K_ZERO_C;
            coef_i1_r  <= {AMP_W{1'b0}};
            coef_q1_r  <= {AMP_W{1'b0}};
            v1_r       <= 1'b0;
            cs1_r      <= 1'b0;
        end else begin
            v1_r  <= tick_run_s;
            cs1_r <= tick_run_s && (k_r == K_ZERO_C);
            if (tick_run_s) begin
                addr_sin_r <= addr_sin_s;
                addr_cos_r <= addr_sin_s + QUARTER_C;
                coef_i1_r  <= coef_i_s;
                coef_q1_r  <= coef_q_s;
            end
        end
    end

    // Stage 2: table read (inside the ROM) alongside the coefficients.
    qmod_sin_rom #(
        .TABLE_BITS (TABLE_BITS)
    ) u_rom (
        .clock    (clock),
        .reset_n  (reset_n),
        .addr_sin (addr_sin_r),
        .addr_cos (addr_cos_r),
        .sin_val  (sin_s),
        .cos_val  (cos_s)
    );

    // Stage 2 side-band registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            coef_i2_r <= {AMP_W{1'b0}};
            coef_q2_r <= {AMP_W{1'b0}};
            v2_r      <= 1'b0;
            cs2_r     <= 1'b0;
        end else begin
            coef_i2_r <= coef_i1_r;
            coef_q2_r <= coef_q1_r;
            v2_r      <= v1_r;
            cs2_r     <= cs1_r;
        end
    end

    // Stage 3: 32x16 signed products, exact in 48 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prod_i_r <= 48'sd0;
            prod_q_r <= 48'sd0;
            v3_r     <= 1'b0;
            cs3_r    <= 1'b0;
        end else begin
            prod_i_r <= 48'(coef_i2_r) * 48'(sin_s);
            prod_q_r <= 48'(coef_q2_r) * 48'(cos_s);
            v3_r     <= v2_r;
            cs3_r    <= cs2_r;
        end
    end

    assign sum_s = 49'(prod_i_r) + 49'(prod_q_r);

    // Stage 4: sign-extended sum and output strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out       <= {OUT_W{1'b0}};
            data_valid_out <= 1'b0;
            cycle_start    <= 1'b0;
        end else begin
            data_out       <= {{(OUT_W-49){sum_s[48]}}, sum_s};
            data_valid_out <= v3_r;
            cycle_start    <= cs3_r;
        end
    end

endmodule

// File: tb/tb_quadrature_modulator.sv
module tb_quadrature_modulator;

    logic               clock;
    logic               reset_n;
    logic               enable;
    logic [15:0]        ptos_x_ciclo;
    logic signed [31:0] amp_i;
    logic signed [31:0] amp_q;
    logic               amp_valid;
    logic               sample_tick;
    logic signed [63:0] data_out;
    logic               data_valid_out;
    logic               cycle_start;
    logic               running;

    int n_checks = 0;
    int n_fail   = 0;

    longint obs_d[$];
    bit     obs_cs[$];
    longint exp_d[$];
    bit     exp_cs[$];

    quadrature_modulator dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .ptos_x_ciclo   (ptos_x_ciclo),
        .amp_i          (amp_i),
        .amp_q          (amp_q),
        .amp_valid      (amp_valid),
        .sample_tick    (sample_tick),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .cycle_start    (cycle_start),
        .running        (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
        end
    endtask

    // Advance one cycle and record any valid sample.
    task automatic step_rec();
        step();
        if (data_valid_out) begin
            obs_d.push_back(data_out);
            obs_cs.push_back(cycle_start);
        end
    endtask

    task automatic expect_s(input longint d, input bit cs);
        exp_d.push_back(d);
        exp_cs.push_back(cs);
    endtask

    task automatic check_obs(input string tag);
        chk({tag, "_count"}, 64'(obs_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < obs_d.size()) begin
                chk({tag, "_data"}, obs_d[i], exp_d[i]);
                chk_bit({tag, "_cs"}, obs_cs[i], exp_cs[i]);
            end
        end
        obs_d.delete();
        obs_cs.delete();
        exp_d.delete();
        exp_cs.delete();
    endtask

    // Go idle, load amplitudes, then enter RUN with the given points per cycle.
    task automatic restart(input logic [15:0] p, input int ai, input int aq);
        enable      = 1'b0;
        sample_tick = 1'b0;
        amp_i       = ai;
        amp_q       = aq;
        amp_valid   = 1'b1;
        step();
        amp_valid = 1'b0;
        step();
        step();
        chk_bit("idle_running", running, 1'b0);
        ptos_x_ciclo = p;
        enable       = 1'b1;
        step();
        chk_bit("run_running", running, 1'b1);
    endtask

    // n back-to-back ticks from k = 0 on an N = 4 carrier; checks latency per cycle.
    task automatic burst4(input int n, input longint e0, input longint e1,
                          input longint e2, input longint e3, input string tag);
        longint e[4];
        int     idx;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int c = 0; c < n + 4; c++) begin
            sample_tick = (c < n);
            step();
            if (c >= 3 && (c - 3) < n) begin
                idx = (c - 3) % 4;
                chk_bit({tag, "_valid"}, data_valid_out, 1'b1);
                chk({tag, "_data"}, data_out, e[idx]);
                chk_bit({tag, "_cs"}, cycle_start, idx == 0);
            end else begin
                chk_bit({tag, "_novalid"}, data_valid_out, 1'b0);
            end
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        int j;
        reset_n      = 1'b0;
        enable       = 1'b0;
        ptos_x_ciclo = 16'd0;
        amp_i        = 32'sd0;
        amp_q        = 32'sd0;
        amp_valid    = 1'b0;
        sample_tick  = 1'b0;
        step();
        step();
        chk("rst_data", data_out, 64'sd0);
        chk_bit("rst_valid", data_valid_out, 1'b0);
        chk_bit("rst_cs", cycle_start, 1'b0);
        chk_bit("rst_running", running, 1'b0);
        reset_n = 1'b1;
        step();

        // Basic carrier, in-phase only and quadrature only.
        restart(16'd4, 1000, 0);
        burst4(8, 0, 32767000, 0, -32767000, "c1");
        restart(16'd4, 0, -2);
        burst4(8, -65534, 0, 65534, 0, "c2");

        // Points-per-cycle rounding down and clamping.
        restart(16'd6, 1000, 0);
        burst4(4, 0, 32767000, 0, -32767000, "p6");
        restart(16'd1, 3, 5);
        burst4(4, 163835, 98301, -163835, -98301, "p1");

        // 5000 points -> full 1024-entry cycle, step 1.
        restart(16'd5000, 1, 0);
        for (int c = 0; c < 1026 + 4; c++) begin
            sample_tick = (c < 1026);
            step();
            if (c >= 3 && (c - 3) < 1026) begin
                j = c - 3;
                chk_bit("p5000_valid", data_valid_out, 1'b1);
                chk_bit("p5000_cs", cycle_start, (j % 1024) == 0);
                if (j == 0 || j == 1024) chk("p5000_d0", data_out, 64'sd0);
                if (j == 1)    chk("p5000_d1", data_out, 64'sd201);
                if (j == 256)  chk("p5000_d256", data_out, 64'sd32767);
                if (j == 1023) chk("p5000_d1023", data_out, -64'sd201);
            end
        end
        sample_tick = 1'b0;

        // Amplitude change in the middle of a carrier cycle (k = 2).
        restart(16'd4, 1000, 0);
        sample_tick = 1'b1;
        step_rec();
        step_rec();
        sample_tick = 1'b0;
        amp_i       = 32'sd2000;
        amp_valid   = 1'b1;
        step_rec();
        amp_valid = 1'b0;
        step_rec();
        sample_tick = 1'b1;
        repeat (4) step_rec();
        sample_tick = 1'b0;
        repeat (4) step_rec();
        expect_s(0, 1'b1);
        expect_s(32767000, 1'b0);
        expect_s(0, 1'b0);
`ifdef QMOD_COEF_SYNC_EN
        expect_s(-32767000, 1'b0);
`else
        expect_s(-65534000, 1'b0);
`endif
        expect_s(0, 1'b1);
        expect_s(65534000, 1'b0);
        check_obs("coef");

        // Enable dropped with three ticks in flight; later ticks ignored.
        restart(16'd4, 1000, 0);
        sample_tick = 1'b1;
        step_rec();
        step_rec();
        enable = 1'b0;
        step_rec();
        chk_bit("drop_running", running, 1'b0);
        repeat (6) step_rec();
        sample_tick = 1'b0;
        repeat (4) step_rec();
        expect_s(0, 1'b1);
        expect_s(32767000, 1'b0);
        expect_s(0, 1'b0);
        check_obs("drop");

        // Re-enable with a tick on the IDLE->RUN edge: that tick is ignored.
        enable      = 1'b1;
        sample_tick = 1'b1;
        step_rec();
        repeat (4) step_rec();
        sample_tick = 1'b0;
        repeat (4) step_rec();
        expect_s(0, 1'b1);
        expect_s(32767000, 1'b0);
        expect_s(0, 1'b0);
        expect_s(-32767000, 1'b0);
        check_obs("reen");

        // Asynchronous reset in the middle of a burst.
        restart(16'd4, 0, -2);
        sample_tick = 1'b1;
        repeat (4) step();
        chk_bit("prerst_valid", data_valid_out, 1'b1);
        chk("prerst_data", data_out, -64'sd65534);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_data", data_out, 64'sd0);
        chk_bit("arst_valid", data_valid_out, 1'b0);
        chk_bit("arst_cs", cycle_start, 1'b0);
        chk_bit("arst_running", running, 1'b0);
        #1;
        sample_tick = 1'b0;
        enable      = 1'b1;
        reset_n     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk_bit("postrst_novalid", data_valid_out, 1'b0);
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        chk_bit("postrst_wait", data_valid_out, 1'b0);
        step();
        chk_bit("postrst_valid", data_valid_out, 1'b1);
        chk("postrst_data", data_out, 64'sd0);
        chk_bit("postrst_cs", cycle_start, 1'b1);
        step();
        chk_bit("postrst_single", data_valid_out, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
